cache_mem_arbiter: RTL and testbench

//  Shares the single RAM port between the instruction-fetch and data-access

---
 rtl/cache_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares the single RAM port between the instruction-fetch and data-access
//   streams of the cache block. One access is granted at a time through a
//   registered grant state; every grant is watched by a timeout counter.
//
// Ports
//   CLK, nRST          clock (rising edge), synchronous active-low reset
//   iREN, iaddr        instruction read request / word address
//   iwait, iload       instruction wait (1 = not done) / read data
//   dREN, dWEN         data read / write request
//   daddr, dstore      data word address / write value
//   dwait, dload       data wait (1 = not done) / read data
//   ramREN, ramWEN     RAM read / write enable
//   ramaddr, ramstore  RAM address / write value
//   ramload, ramstate  RAM read data / status (FREE=0 BUSY=1 ACCESS=2 ERROR=3)
//   err                sticky error flag (RAM ERROR or grant timeout)
//
// Parameter
//   TIMEOUT            max grant cycles before abort (>= 2)
//
// Build option
//   ARB_ROUND_ROBIN_EN defined: on simultaneous requests grant the side that
//                      did not complete last. Undefined: data side always wins.
//
// state | meaning
// IDLE  | no grant; arbitrate pending requests for the next cycle
// IGNT  | RAM port driven by the instruction-fetch side
// DGNT  | RAM port driven by the data-access side

module cache_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int            CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [1:0]    RAM_ACCESS = 2'd2;
  localparam logic [1:0]    RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] tmo_cnt, next_tmo_cnt;
  logic          last_d, next_last_d;
  logic          next_err;
  logic          dreq;
  logic          req_held;

  assign dreq  = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

`ifndef ARB_ROUND_ROBIN_EN
  // last_d is only consulted by the round-robin build.
  logic unused_last_d;
  assign unused_last_d = last_d;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      err     <= 1'b0;
      last_d  <= 1'b0;
    end else begin
      state   <= next_state;
      tmo_cnt <= next_tmo_cnt;
      err     <= next_err;
      last_d  <= next_last_d;
    end
  end

  always_comb begin
    next_state  = state;
    next_last_d = last_d;
    next_err    = err;
    req_held    = 1'b0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iwait       = 1'b1;
    dwait       = 1'b1;

    case (state)
      IDLE: begin
        if (dreq && iREN) begin
`ifdef ARB_ROUND_ROBIN_EN
          next_state = last_d ? IGNT : DGNT;
`else
          next_state = DGNT;
`endif
        end else if (dreq) begin
          next_state = DGNT;
        end else if (iREN) begin
          next_state = IGNT;
        end
      end
      IGNT: begin
        ramREN   = 1'b1;
        ramaddr  = iaddr;
        iwait    = (ramstate != RAM_ACCESS);
        req_held = iREN;
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = (ramstate != RAM_ACCESS);
        req_held = dreq;
      end
      default: next_state = IDLE;
    endcase

    // Grant exits, highest priority first. Every exit returns to IDLE.
    if (state == IGNT || state == DGNT) begin
      if (ramstate == RAM_ACCESS) begin
        next_state  = IDLE;
        next_last_d = (state == DGNT);
      end else if (ramstate == RAM_ERROR) begin
        next_state = IDLE;
        next_err   = 1'b1;
      end else if (tmo_cnt == TMO_LAST) begin
        next_state = IDLE;
        next_err   = 1'b1;
      end else if (!req_held) begin
        next_state = IDLE;
      end
    end

    // Counter restarts at zero on every grant entry; the exit at TMO_LAST
    // bounds it, so it never wraps.
    if (state != IDLE && next_state != IDLE)
      next_tmo_cnt = tmo_cnt + CW'(1);
    else
      next_tmo_cnt = '0;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  cache_mem_arbiter #(.TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    tick();
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h10; daddr = 32'h20; dstore = 32'h30; ramstate = BUSY; ramload = '0;
    tick();
    tick();
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL reset_ramREN got=%0b want=0", ramREN); end
    checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL reset_ramWEN got=%0b want=0", ramWEN); end
    checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL reset_waits got=%0b%0b want=11", iwait, dwait); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b want=0", err); end
    // reset taken in the middle of a grant
    nRST = 1'b1; dREN = 1'b0; dWEN = 1'b0;
    tick();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h10) begin errors++; $display("FAIL reset_pregrant got=%0b/%0h want=1/10", ramREN, ramaddr); end
    nRST = 1'b0;
    tick();
    checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || iwait !== 1'b1) begin errors++; $display("FAIL reset_midgrant got=%0b/%0h/%0b want=0/0/1", ramREN, ramaddr, iwait); end
  endtask

  task automatic test_single_ifetch;
    do_reset();
    ramstate = BUSY; iREN = 1'b1; iaddr = 32'h40;
    #1;
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL ifetch_arb_cycle got=%0b/%0b want=0/1", ramREN, iwait); end
    tick();
    checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin errors++; $display("FAIL ifetch_grant1 got=%0b/%0b/%0h want=1/0/40", ramREN, ramWEN, ramaddr); end
    checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL ifetch_grant1_wait got=%0b%0b want=11", iwait, dwait); end
    tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1;
    checks++; if (iwait !== 1'b0 || iload !== 32'hDEADBEEF) begin errors++; $display("FAIL ifetch_done got=%0b/%0h want=0/deadbeef", iwait, iload); end
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin errors++; $display("FAIL ifetch_done_ram got=%0b/%0h want=1/40", ramREN, ramaddr); end
    tick();
    iREN = 1'b0; ramstate = FREE;
    #1;
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL ifetch_idle got=%0b/%0b want=0/1", ramREN, iwait); end
  endtask

  task automatic test_contention;
    logic [3:0] exp_seq;
    int d_left, i_left;
    logic exp_d;
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = 4'b0101;   // D, I, D, I (bit k = 1 means data grant)
`else
    exp_seq = 4'b0011;   // D, D, I, I
`endif
    do_reset();
    d_left = 2; i_left = 2;
    ramstate = BUSY;
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'd5;
    for (int k = 0; k < 4; k++) begin
      exp_d = exp_seq[k];
      tick();
      if (exp_d) begin
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'd5) begin
          errors++; $display("FAIL contention_grant%0d got=wen%0b ren%0b addr%0h st%0h want=D write to 80", k, ramWEN, ramREN, ramaddr, ramstore); end
      end else begin
        checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h44) begin
          errors++; $display("FAIL contention_grant%0d got=wen%0b ren%0b addr%0h want=I read of 44", k, ramWEN, ramREN, ramaddr); end
      end
      tick();
      ramstate = ACCESS;
      #1;
      checks++; if (iwait !== exp_d || dwait !== !exp_d) begin
        errors++; $display("FAIL contention_done%0d got=iwait%0b dwait%0b want=iwait%0b dwait%0b", k, iwait, dwait, exp_d, !exp_d); end
      tick();
      ramstate = BUSY;
      if (exp_d) begin d_left--; if (d_left == 0) dWEN = 1'b0; end
      else begin i_left--; if (i_left == 0) iREN = 1'b0; end
      #1;
      checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin
        errors++; $display("FAIL contention_idle%0d got=%0b%0b%0b%0b want=0011", k, ramREN, ramWEN, iwait, dwait); end
    end
  endtask

  task automatic test_both_rw;
    do_reset();
    ramstate = BUSY; dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234;
    tick();
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1234 || ramaddr !== 32'h100) begin
      errors++; $display("FAIL both_rw got=wen%0b ren%0b st%0h addr%0h want=wen1 ren0 st1234 addr100", ramWEN, ramREN, ramstore, ramaddr); end
    ramstate = ACCESS;
    #1;
    checks++; if (dwait !== 1'b0) begin errors++; $display("FAIL both_rw_done got=%0b want=0", dwait); end
    tick();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    tick();
  endtask

  task automatic test_timeout;
    logic seen_low;
    do_reset();
    seen_low = 1'b0;
    ramstate = BUSY; dREN = 1'b1; daddr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (dwait !== 1'b1) seen_low = 1'b1;
      checks++; if (ramREN !== 1'b1 || err !== 1'b0) begin
        errors++; $display("FAIL timeout_grant%0d got=ren%0b err%0b want=ren1 err0", k, ramREN, err); end
    end
    tick();
    if (dwait !== 1'b1) seen_low = 1'b1;
    checks++; if (err !== 1'b1 || ramREN !== 1'b0) begin
      errors++; $display("FAIL timeout_abort got=err%0b ren%0b want=err1 ren0", err, ramREN); end
    tick();
    if (dwait !== 1'b1) seen_low = 1'b1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h200) begin
      errors++; $display("FAIL timeout_regrant got=ren%0b addr%0h want=ren1 addr200", ramREN, ramaddr); end
    // counter restarted: still granted three cycles later
    tick(); tick(); tick();
    if (dwait !== 1'b1) seen_low = 1'b1;
    checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL timeout_restart got=ren%0b want=1", ramREN); end
    checks++; if (seen_low !== 1'b0) begin errors++; $display("FAIL timeout_dwait got=low seen want=never low"); end
    dREN = 1'b0;
    tick();

    // ACCESS in the last allowed cycle beats the timeout
    do_reset();
    ramstate = BUSY; dREN = 1'b1; daddr = 32'h204;
    tick(); tick(); tick(); tick();
    ramstate = ACCESS;
    #1;
    checks++; if (dwait !== 1'b0) begin errors++; $display("FAIL timeout_edge_done got=%0b want=0", dwait); end
    tick();
    dREN = 1'b0; ramstate = FREE;
    #1;
    checks++; if (err !== 1'b0 || ramREN !== 1'b0) begin errors++; $display("FAIL timeout_edge_err got=err%0b ren%0b want=err0 ren0", err, ramREN); end
  endtask

  task automatic test_error;
    do_reset();
    ramstate = BUSY; dREN = 1'b1; daddr = 32'h300;
    tick();
    ramstate = ERROR;
    #1;
    checks++; if (dwait !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL error_cycle got=dwait%0b err%0b want=dwait1 err0", dwait, err); end
    tick();
    ramstate = FREE;
    #1;
    checks++; if (err !== 1'b1 || ramREN !== 1'b0 || dwait !== 1'b1) begin
      errors++; $display("FAIL error_abort got=err%0b ren%0b dwait%0b want=err1 ren0 dwait1", err, ramREN, dwait); end
    tick();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin errors++; $display("FAIL error_retry got=ren%0b addr%0h want=ren1 addr300", ramREN, ramaddr); end
    ramstate = ACCESS;
    #1;
    checks++; if (dwait !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL error_sticky got=dwait%0b err%0b want=dwait0 err1", dwait, err); end
    tick();
    dREN = 1'b0; ramstate = FREE;
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL error_hold got=%0b want=1", err); end
  endtask

  task automatic test_abandon;
    logic seen_low;
    do_reset();
    seen_low = 1'b0;
    ramstate = BUSY; iREN = 1'b1; iaddr = 32'h48;
    tick();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h48) begin errors++; $display("FAIL abandon_grant got=ren%0b addr%0h want=ren1 addr48", ramREN, ramaddr); end
    iREN = 1'b0;
    #1;
    if (iwait !== 1'b1) seen_low = 1'b1;
    tick();
    if (iwait !== 1'b1) seen_low = 1'b1;
    checks++; if (ramREN !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL abandon_idle got=ren%0b err%0b want=ren0 err0", ramREN, err); end
    tick();
    if (iwait !== 1'b1) seen_low = 1'b1;
    checks++; if (ramREN !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL abandon_stay got=ren%0b err%0b want=ren0 err0", ramREN, err); end
    checks++; if (seen_low !== 1'b0) begin errors++; $display("FAIL abandon_handshake got=iwait low want=never low"); end
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #2;
    test_reset();
    test_single_ifetch();
    test_contention();
    test_both_rw();
    test_timeout();
    test_error();
    test_abandon();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
